// File: rtl/iir_io_pkg.sv
// Shared types and widths for the IIR sample server slice.
// Holds the bus widths and the FSM state encoding used by the server.
`timescale 1ns/1ps
package iir_io_pkg;

   localparam int unsigned ADDR_W = 20;
   localparam int unsigned DATA_W = 16;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_FILL  = 2'd1;
   localparam state_t ST_RUN   = 2'd2;
   localparam state_t ST_DRAIN = 2'd3;

endpackage

// File: rtl/iir_sample_server_if.sv
// Host-side stream interface of the IIR sample server.
// Input stream:  in_valid/in_ready/in_data/in_last (host -> server).
// Output stream: out_valid/out_ready/out_data/out_last (server -> host).
// master = host side, slave = server side.
`timescale 1ns/1ps
interface iir_sample_server_if;
   import iir_io_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last
   );

endinterface

// File: rtl/iir_sample_ram.sv
// Sample buffer: register array with one synchronous write port and one
// asynchronous read port. Contents are not reset.
// Ports: clk, we/waddr/wdata (write), raddr/rdata_c (combinational read).
`timescale 1ns/1ps
module iir_sample_ram
   import iir_io_pkg::*;
#(
   parameter int unsigned AW = 6
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata_c
);

   localparam int unsigned DEPTH = 2**AW;

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/iir_sample_server.sv
// Memory-side responder for one IIR filter instance.
// Buffers a host sample block, releases the filter from reset and serves its
// reads, captures its writes, then streams the results back to the host.
// Ports: clk, rst (async, active-high), host (stream interface, slave),
//        filter side f_load/f_raddr/f_din, f_wen/f_waddr/f_yn, f_data_done,
//        f_finish, filt_rst; status busy, err_timeout.
// Optional: define OUT_CHECKSUM_EN to add a 16-bit rotate-xor checksum port
// over the words handed to the host during DRAIN.
`timescale 1ns/1ps
module iir_sample_server
   import iir_io_pkg::*;
#(
   parameter int unsigned AW      = 6,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   iir_sample_server_if.slave host,
   output logic              filt_rst,
   input  logic              f_load,
   input  logic [ADDR_W-1:0] f_raddr,
   output logic [DATA_W-1:0] f_din,
   input  logic              f_wen,
   input  logic [ADDR_W-1:0] f_waddr,
   input  logic [DATA_W-1:0] f_yn,
   output logic              f_data_done,
   input  logic              f_finish,
   output logic              busy,
   output logic              err_timeout
`ifdef OUT_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] checksum
`endif
);

   localparam int unsigned DEPTH = 2**AW;
   localparam int unsigned CW    = AW + 1;

   state_t            state_q, state_d;
   logic [CW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [ADDR_W-1:0] timer_q, timer_d;
   logic [DEPTH-1:0]  valid_q, valid_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] chk_q, chk_d;

   logic              in_fire, out_fire, rd_in_range, wr_ok, timer_hit;
   logic [ADDR_W-1:0] count_ext;
   logic [DATA_W-1:0] in_rdata, out_rdata;

   // Address checks are full-width so out-of-block addresses never alias.
   assign count_ext   = ADDR_W'(count_q);
   assign rd_in_range = f_raddr < count_ext;
   assign wr_ok       = (state_q == ST_RUN) && f_wen && (f_waddr < count_ext);
   assign timer_hit   = timer_q == (count_ext + ADDR_W'(TIMEOUT));

   assign host.in_ready  = (state_q == ST_IDLE) || (state_q == ST_FILL);
   assign host.out_valid = (state_q == ST_DRAIN) && (rd_ptr_q < count_q);
   assign host.out_data  = (host.out_valid && valid_q[rd_ptr_q[AW-1:0]]) ? out_rdata : '0;
   assign host.out_last  = host.out_valid && (rd_ptr_q == count_q - CW'(1));
   assign in_fire        = host.in_valid && host.in_ready;
   assign out_fire       = host.out_valid && host.out_ready;

   assign filt_rst    = state_q != ST_RUN;
   assign busy        = state_q != ST_IDLE;
   assign err_timeout = err_q;
   assign f_din       = ((state_q == ST_RUN) && f_load && rd_in_range) ? in_rdata : '0;
   assign f_data_done = (state_q == ST_RUN) && !rd_in_range;

`ifdef OUT_CHECKSUM_EN
   assign checksum = chk_q;
`endif

   iir_sample_ram #(.AW(AW)) u_in_mem (
      .clk     (clk),
      .we      (in_fire),
      .waddr   (wr_ptr_q[AW-1:0]),
      .wdata   (host.in_data),
      .raddr   (f_raddr[AW-1:0]),
      .rdata_c (in_rdata)
   );

   iir_sample_ram #(.AW(AW)) u_out_mem (
      .clk     (clk),
      .we      (wr_ok),
      .waddr   (f_waddr[AW-1:0]),
      .wdata   (f_yn),
      .raddr   (rd_ptr_q[AW-1:0]),
      .rdata_c (out_rdata)
   );

   // Next-state logic for the block lifecycle.
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      timer_d  = timer_q;
      valid_d  = valid_q;
      err_d    = err_q;
      chk_d    = chk_q;
      case (state_q)
         ST_IDLE, ST_FILL: begin
            if (in_fire) begin
               wr_ptr_d = wr_ptr_q + CW'(1);
               state_d  = ST_FILL;
               if (host.in_last || (wr_ptr_q == CW'(DEPTH - 1))) begin
                  state_d = ST_RUN;
                  count_d = wr_ptr_q + CW'(1);
                  valid_d = '0;
                  timer_d = '0;
                  chk_d   = '0;
               end
            end
         end
         ST_RUN: begin
            timer_d = timer_q + ADDR_W'(1);
            if (wr_ok) valid_d[f_waddr[AW-1:0]] = 1'b1;
            if (f_finish) begin
               state_d = ST_DRAIN;
            end else if (timer_hit) begin
               state_d = ST_DRAIN;
               err_d   = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (out_fire) begin
               rd_ptr_d = rd_ptr_q + CW'(1);
               chk_d    = {chk_q[DATA_W-2:0], chk_q[DATA_W-1]} ^ host.out_data;
               if (host.out_last) begin
                  state_d  = ST_IDLE;
                  wr_ptr_d = '0;
                  rd_ptr_d = '0;
                  count_d  = '0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         timer_q  <= '0;
         valid_q  <= '0;
         err_q    <= 1'b0;
         chk_q    <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         timer_q  <= timer_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         chk_q    <= chk_d;
      end
   end

endmodule

// File: tb/tb_iir_sample_server.sv
// Scoreboard bench for iir_sample_server: a behavioural block model queues
// the expected output words; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_iir_sample_server;
   import iir_io_pkg::*;

   localparam int unsigned DEPTH   = 64;
   localparam int unsigned TIMEOUT = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        filt_rst, f_data_done, busy, err_timeout;
   logic        f_load = 1'b0, f_wen = 1'b0, f_finish = 1'b0;
   logic [19:0] f_raddr = '0, f_waddr = '0;
   logic [15:0] f_yn = '0, f_din;
`ifdef OUT_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   iir_sample_server_if ifc ();

   iir_sample_server #(.AW(6), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .host        (ifc),
      .filt_rst    (filt_rst),
      .f_load      (f_load),
      .f_raddr     (f_raddr),
      .f_din       (f_din),
      .f_wen       (f_wen),
      .f_waddr     (f_waddr),
      .f_yn        (f_yn),
      .f_data_done (f_data_done),
      .f_finish    (f_finish),
      .busy        (busy),
      .err_timeout (err_timeout)
`ifdef OUT_CHECKSUM_EN
      ,
      .checksum    (checksum)
`endif
   );

   int          n_chk = 0;
   int          n_pass = 0;
   logic [16:0] exp_q[$];
   logic [16:0] mon_e;
   logic [15:0] smp[$];
   logic [15:0] mexp[DEPTH];
   int          cnt = 0;
   logic [15:0] mchk = '0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
   endfunction

   // Output monitor: every accepted result word must match the model.
   always @(negedge clk) begin
      if (!rst && ifc.out_valid && ifc.out_ready) begin
         if (exp_q.size() == 0) begin
            check("sb_underflow", 32'(exp_q.size()), 32'd1);
         end else begin
            mon_e = exp_q.pop_front();
            check("out_word", {15'b0, ifc.out_last, ifc.out_data}, {15'b0, mon_e});
         end
      end
   end

   // Model: a block's result i is the last in-range write to i, else zero.
   task automatic push_block();
      logic [15:0] c;
      c = '0;
      for (int i = 0; i < cnt; i++) begin
         exp_q.push_back({(i == cnt - 1), mexp[i]});
         c = {c[14:0], c[15]} ^ mexp[i];
      end
      mchk = c;
   endtask

   task automatic send_block(input bit use_last);
      cnt = smp.size();
      for (int i = 0; i < DEPTH; i++) mexp[i] = '0;
      check("in_ready_idle", ifc.in_ready, 1);
      for (int i = 0; i < smp.size(); i++) begin
         ifc.in_valid = 1'b1;
         ifc.in_data  = smp[i];
         ifc.in_last  = use_last && (i == smp.size() - 1);
         @(posedge clk); #1;
      end
      ifc.in_valid = 1'b0;
      ifc.in_last  = 1'b0;
      check("filt_rst_run", filt_rst, 0);
      check("busy_run", busy, 1);
      check("in_ready_run", ifc.in_ready, 0);
   endtask

   task automatic fread(input int a);
      f_load  = 1'b1;
      f_raddr = 20'(a);
      #1;
      check("f_din", f_din, (a < cnt) ? 32'(smp[a]) : 32'd0);
      check("f_data_done", f_data_done, (a >= cnt) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
      f_load = 1'b0;
   endtask

   task automatic fcycle(input bit wen, input int a, input logic [15:0] d, input bit fin);
      f_wen    = wen;
      f_waddr  = 20'(a);
      f_yn     = d;
      f_finish = fin;
      @(posedge clk); #1;
      if (wen && a < cnt) mexp[a] = d;
      f_wen    = 1'b0;
      f_finish = 1'b0;
      if (fin) push_block();
   endtask

   task automatic drain(input bit rnd);
      int cyc;
      cyc = 0;
      while (busy && cyc < 3000) begin
         ifc.out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         @(posedge clk); #1;
         cyc++;
      end
      ifc.out_ready = 1'b0;
      check("drain_idle", busy, 0);
      check("in_ready_after", ifc.in_ready, 1);
      check("sb_empty", 32'(exp_q.size()), 0);
`ifdef OUT_CHECKSUM_EN
      check("checksum", checksum, 32'(mchk));
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, cyc;
      ifc.in_valid  = 1'b0;
      ifc.in_data   = '0;
      ifc.in_last   = 1'b0;
      ifc.out_ready = 1'b0;
      #1;
      check("rst_in_ready", ifc.in_ready, 1);
      check("rst_out_valid", ifc.out_valid, 0);
      check("rst_out_last", ifc.out_last, 0);
      check("rst_out_data", ifc.out_data, 0);
      check("rst_filt_rst", filt_rst, 1);
      check("rst_f_din", f_din, 0);
      check("rst_data_done", f_data_done, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err_timeout, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic block with explicit backpressure mid-drain.
      smp = '{16'h0100, 16'h0200, 16'hFF00, 16'h0000};
      send_block(1);
      fread(2);
      fread(4);
      for (int a = 0; a < 4; a++) fcycle(1, a, 16'(16'h0011 + a), 0);
      fcycle(0, 0, 16'h0, 1);
      ifc.out_ready = 1'b1;
      @(posedge clk); #1;
      ifc.out_ready = 1'b0;
      repeat (3) begin
         check("bp_valid", ifc.out_valid, 1);
         check("bp_hold", {15'b0, ifc.out_last, ifc.out_data}, {15'b0, exp_q[0]});
         @(posedge clk); #1;
      end
      drain(0);

      // Skipped address reads back as zero; out-of-range write is ignored.
      smp = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      send_block(1);
      fcycle(1, 0, 16'hA000, 0);
      fcycle(1, 1, 16'hA001, 0);
      fcycle(1, 3, 16'hA003, 0);
      fcycle(1, 7, 16'hBEEF, 0);
      fcycle(0, 0, 16'h0, 1);
      drain(0);

      // Randomized blocks.
      repeat (6) begin
         n = $urandom_range(1, 12);
         smp.delete();
         for (int i = 0; i < n; i++) smp.push_back(16'($urandom));
         send_block(1);
         repeat (3) fread($urandom_range(0, n + 3));
         for (int a = 0; a < n; a++)
            if ($urandom_range(0, 3) != 0) fcycle(1, a, 16'($urandom), 0);
         fcycle(1, n + $urandom_range(0, 20), 16'($urandom), 0);
         fcycle(1, $urandom_range(0, n - 1), 16'($urandom), 1);
         drain(1);
      end

      // Full buffer without in_last, filter never finishes.
      smp.delete();
      for (int i = 0; i < DEPTH; i++) smp.push_back(16'($urandom));
      send_block(0);
      check("count_full_err0", err_timeout, 0);
      fread(63);
      fread(64);
      cyc = 2;
      while (!ifc.out_valid && cyc < 400) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("timeout_window", 32'((cyc >= DEPTH + TIMEOUT) && (cyc <= DEPTH + TIMEOUT + 2)), 1);
      check("err_timeout", err_timeout, 1);
      push_block();
      drain(1);

      // Reset in the middle of RUN, then a one-sample block.
      smp = '{16'h0abc, 16'h0def, 16'h0123};
      send_block(1);
      fread(1);
      rst = 1'b1;
      #1;
      check("mid_rst_filt_rst", filt_rst, 1);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_in_ready", ifc.in_ready, 1);
      check("mid_rst_out_valid", ifc.out_valid, 0);
      check("mid_rst_err", err_timeout, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      smp = '{16'h5a5a};
      send_block(1);
      fread(0);
      fread(1);
      fcycle(1, 0, 16'hC0DE, 1);
      drain(1);

      // Two-word block 0x0001, 0x0002 (rotate-xor checksum folds to zero).
      smp = '{16'h7777, 16'h8888};
      send_block(1);
      fcycle(1, 0, 16'h0001, 0);
      fcycle(1, 1, 16'h0002, 1);
      drain(1);
`ifdef OUT_CHECKSUM_EN
      check("checksum_2w", checksum, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
